// File: rtl/store_rmw_if.sv
// Store request and word-memory port bundle for store_rmw_unit.
// The slave side is the unit; the master side drives requests and memory.
interface store_rmw_if;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic [1:0]  reqSize;
  logic [31:0] memAddr;
  logic        memRe;
  logic        memRValid;
  logic [31:0] memRData;
  logic        memWe;
  logic [31:0] memWData;
  logic        done;
  logic        error;

  modport slave (
    input  reqValid, reqAddr, reqData, reqSize,
    input  memRValid, memRData,
    output reqReady, memAddr, memRe, memWe, memWData,
    output done, error
  );

  modport master (
    output reqValid, reqAddr, reqData, reqSize,
    output memRValid, memRData,
    input  reqReady, memAddr, memRe, memWe, memWData,
    input  done, error
  );
endinterface

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data memory: SW direct write, SH/SB via
// read-modify-write using the big-endian lane map shared with loads.
module store_rmw_unit #(
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst_n,
  store_rmw_if.slave  bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    ERR
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          illegal;
  logic          is_word;
  logic [31:0]   merged;

  always_comb begin
    illegal = (bus.reqSize == 2'd3)
            | ((bus.reqSize == 2'd1) & bus.reqAddr[0])
            | ((bus.reqSize == 2'd0) & (bus.reqAddr[1:0] != 2'd0));
    is_word = (bus.reqSize == 2'd0) & (bus.reqAddr[1:0] == 2'd0);
  end

  // lane 0 is the most significant byte
  always_comb begin
    merged = bus.memRData;
    case ({size_q, off_q})
      4'b01_00: merged[31:16] = data_q;
      4'b01_10: merged[15:0]  = data_q;
      4'b10_00: merged[31:24] = data_q[7:0];
      4'b10_01: merged[23:16] = data_q[7:0];
      4'b10_10: merged[15:8]  = data_q[7:0];
      4'b10_11: merged[7:0]   = data_q[7:0];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    size_d  = size_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          addr_d = {bus.reqAddr[31:2], 2'b00};
          data_d = bus.reqData[15:0];
          size_d = bus.reqSize;
          off_d  = bus.reqAddr[1:0];
          unique case (1'b1)
            illegal: state_d = ERR;
            is_word: begin
              state_d = WRITE;
              wdata_d = bus.reqData;
            end
            default: state_d = READ;
          endcase
        end
      end
      READ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.memRValid) begin
          wdata_d = merged;
          state_d = WRITE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    re_d   = (state_d == READ);
    we_d   = (state_d == WRITE);
    done_d = (state_d == WRITE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      size_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.reqReady = (state_q == IDLE);
  assign bus.memAddr  = addr_q;
  assign bus.memWData = wdata_q;
  assign bus.memRe    = re_q;
  assign bus.memWe    = we_q;
  assign bus.done     = done_q;
  assign bus.error    = err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed self-checking bench for store_rmw_unit.
// Each scenario task drives one feature and checks it inline.
module tb_store_rmw_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  store_rmw_if bus ();

  store_rmw_unit #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // issue one request and record what the unit does, cycle by cycle
  task automatic run_store(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [1:0]  s,
    input  logic [31:0] rd,
    input  int          rdly,
    input  bit          give_rv,
    output int          re_cnt,
    output int          re_cyc,
    output int          we_cyc,
    output int          done_cyc,
    output int          err_cyc,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output bit          overlap,
    output bit          ready_after
  );
    re_cnt = 0; re_cyc = 0; we_cyc = 0; done_cyc = 0; err_cyc = 0;
    waddr = '0; wdata = '0; overlap = 0; ready_after = 0;
    bus.reqValid = 1'b1;
    bus.reqAddr  = a;
    bus.reqData  = d;
    bus.reqSize  = s;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.reqValid = 1'b0;
      if ((bus.done && bus.error) || (bus.memRe && bus.memWe)) overlap = 1;
      if (bus.memRe) begin
        re_cnt++;
        re_cyc = cyc;
      end
      if (bus.done) done_cyc = cyc;
      if (bus.error) err_cyc = cyc;
      if (bus.memWe) begin
        we_cyc = cyc;
        waddr  = bus.memAddr;
        wdata  = bus.memWData;
      end
      bus.memRValid = give_rv && (re_cyc > 0) && (cyc == re_cyc + rdly);
      bus.memRData  = bus.memRValid ? rd : 32'h0;
      if (we_cyc != 0 || err_cyc != 0) break;
    end
    bus.memRValid = 1'b0;
    @(posedge clk); #1;
    ready_after = bus.reqReady;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.reqValid = 1'b0;
    bus.reqAddr = '0;
    bus.reqData = '0;
    bus.reqSize = '0;
    bus.memRValid = 1'b0;
    bus.memRData = '0;
    #12;
    checks++;
    if ({bus.reqReady, bus.memRe, bus.memWe, bus.done, bus.error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=10000",
        {bus.reqReady, bus.memRe, bus.memWe, bus.done, bus.error});
    end
    checks++;
    if ({bus.memAddr, bus.memWData} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h exp=0", {bus.memAddr, bus.memWData});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    int rc, rcy, wc, dc, ec;
    logic [31:0] wa, wd;
    bit ov, ra;
    run_store(32'h100, 32'hDEADBEEF, 2'd0, 32'h0, 0, 0,
              rc, rcy, wc, dc, ec, wa, wd, ov, ra);
    checks++;
    if (wc !== 1 || dc !== 1) begin
      errors++;
      $display("FAIL sw_latency got we=%0d done=%0d exp 1", wc, dc);
    end
    checks++;
    if (wa !== 32'h100 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_data got a=%h d=%h exp 100 deadbeef", wa, wd);
    end
    checks++;
    if (rc !== 0 || ec !== 0 || ov !== 0 || ra !== 1) begin
      errors++;
      $display("FAIL sw_side got re=%0d err=%0d ov=%0d rdy=%0d exp 0 0 0 1",
        rc, ec, ov, ra);
    end
  endtask

  task automatic test_subword;
    logic [31:0] ta [6] = '{32'h203, 32'h200, 32'h201, 32'h302, 32'h300, 32'h202};
    logic [31:0] td [6] = '{32'hFFFFFFAA, 32'hFFFFFFAA, 32'h123456AA,
                           32'h0000BEEF, 32'h5555BEEF, 32'h0000AA00};
    logic [1:0]  ts [6] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2};
    logic [31:0] tx [6] = '{32'h112233AA, 32'hAA223344, 32'h11AA3344,
                           32'h1122BEEF, 32'hBEEF3344, 32'h11220044};
    int rc, rcy, wc, dc, ec;
    logic [31:0] wa, wd;
    bit ov, ra;
    for (int i = 0; i < 6; i++) begin
      run_store(ta[i], td[i], ts[i], 32'h11223344, 2, 1,
                rc, rcy, wc, dc, ec, wa, wd, ov, ra);
      checks++;
      if (wd !== tx[i]) begin
        errors++;
        $display("FAIL rmw_merge[%0d] got=%h exp=%h", i, wd, tx[i]);
      end
      checks++;
      if (wa !== {ta[i][31:2], 2'b00} || rc !== 1 || rcy !== 1) begin
        errors++;
        $display("FAIL rmw_read[%0d] got a=%h re=%0d recyc=%0d exp a=%h 1 1",
          i, wa, rc, rcy, {ta[i][31:2], 2'b00});
      end
      checks++;
      if (wc !== 4 || dc !== 4 || ec !== 0 || ov !== 0 || ra !== 1) begin
        errors++;
        $display("FAIL rmw_timing[%0d] got we=%0d done=%0d err=%0d ov=%0d rdy=%0d exp 4 4 0 0 1",
          i, wc, dc, ec, ov, ra);
      end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ta [3] = '{32'h301, 32'h402, 32'h500};
    logic [1:0]  ts [3] = '{2'd1, 2'd0, 2'd3};
    int rc, rcy, wc, dc, ec;
    logic [31:0] wa, wd;
    bit ov, ra;
    for (int i = 0; i < 3; i++) begin
      run_store(ta[i], 32'hCAFEF00D, ts[i], 32'h0, 0, 0,
                rc, rcy, wc, dc, ec, wa, wd, ov, ra);
      checks++;
      if (ec !== 1 || rc !== 0 || wc !== 0 || dc !== 0 || ra !== 1) begin
        errors++;
        $display("FAIL illegal[%0d] got err=%0d re=%0d we=%0d done=%0d rdy=%0d exp 1 0 0 0 1",
          i, ec, rc, wc, dc, ra);
      end
    end
  endtask

  task automatic test_timeout;
    int rc, rcy, wc, dc, ec;
    logic [31:0] wa, wd;
    bit ov, ra;
    run_store(32'h603, 32'h000000EE, 2'd2, 32'h0, 0, 0,
              rc, rcy, wc, dc, ec, wa, wd, ov, ra);
    checks++;
    if (ec !== 18 || rc !== 1) begin
      errors++;
      $display("FAIL timeout_cyc got err=%0d re=%0d exp 18 1", ec, rc);
    end
    checks++;
    if (wc !== 0 || dc !== 0 || ra !== 1) begin
      errors++;
      $display("FAIL timeout_side got we=%0d done=%0d rdy=%0d exp 0 0 1", wc, dc, ra);
    end
  endtask

  task automatic test_back_to_back;
    bus.reqValid = 1'b1;
    bus.reqAddr  = 32'h700;
    bus.reqData  = 32'h01020304;
    bus.reqSize  = 2'd0;
    @(posedge clk); #1;
    bus.reqAddr = 32'h704;
    bus.reqData = 32'hA5A5A5A5;
    checks++;
    if (bus.memWe !== 1'b1 || bus.memWData !== 32'h01020304 || bus.reqReady !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got we=%b d=%h rdy=%b exp 1 01020304 0",
        bus.memWe, bus.memWData, bus.reqReady);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.memWe !== 1'b0 || bus.reqReady !== 1'b1 || bus.memAddr !== 32'h700) begin
      errors++;
      $display("FAIL b2b_gap got we=%b rdy=%b a=%h exp 0 1 700",
        bus.memWe, bus.reqReady, bus.memAddr);
    end
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    checks++;
    if (bus.memWe !== 1'b1 || bus.memWData !== 32'hA5A5A5A5 || bus.memAddr !== 32'h704) begin
      errors++;
      $display("FAIL b2b_second got we=%b d=%h a=%h exp 1 a5a5a5a5 704",
        bus.memWe, bus.memWData, bus.memAddr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit bad;
    bus.reqValid = 1'b1;
    bus.reqAddr  = 32'h801;
    bus.reqData  = 32'h00000077;
    bus.reqSize  = 2'd2;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.reqReady, bus.memRe, bus.memWe, bus.done, bus.error} !== 5'b10000 ||
        bus.memAddr !== 32'h0 || bus.memWData !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got ctl=%b a=%h d=%h exp 10000 0 0",
        {bus.reqReady, bus.memRe, bus.memWe, bus.done, bus.error},
        bus.memAddr, bus.memWData);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.memRValid = 1'b1;
    bus.memRData  = 32'h99999999;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.memRValid = 1'b0;
      if (bus.memWe || bus.done) bad = 1;
    end
    checks++;
    if (bad !== 1'b0 || bus.reqReady !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid got wr=%b rdy=%b exp 0 1", bad, bus.reqReady);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_word;
    test_subword;
    test_illegal;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_word;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load data decoder in the CPU memory stage.
- Accepts SW/SH/SB requests and drives a word-only data memory port.
- Word stores are written directly. Half and byte stores do a read-modify-write: read the word, merge the lane (big-endian, same lane map as loads), write back.
- Flags misaligned or illegal stores and read timeouts without touching memory.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT for memRValid before aborting; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- reqValid  input  1  store request valid.
- reqReady  output  1  unit can accept a request (high only in IDLE).
- reqAddr  input  32  byte address; [1:0] is the lane offset.
- reqData  input  32  store data, right-justified for SH/SB.
- reqSize  input  2  0 word, 1 half, 2 byte, 3 illegal.
- memAddr  output  32  word address, {reqAddr[31:2], 2'b00}.
- memRe  output  1  memory read strobe, 1-cycle pulse.
- memRValid  input  1  memRData valid.
- memRData  input  32  memory read data.
- memWe  output  1  memory write strobe, 1-cycle pulse.
- memWData  output  32  full word to write.
- done  output  1  1-cycle pulse: store completed.
- error  output  1  1-cycle pulse: store rejected (misaligned, illegal size, or timeout).

Behaviour:
- Reset (async, rst_n=0): state=IDLE. reqReady=1 once idle; memRe=memWe=done=error=0; memAddr=memWData=0; timeout counter=0.
- Reset mid-operation aborts immediately. No write is issued after reset deasserts.
- All outputs are registered except reqReady, which is (state==IDLE).
- Accept: reqValid & reqReady on a rising edge latches addr, data, size and offset. Requests in non-IDLE states are ignored; the requester holds reqValid.
- Legality check at accept:
  - size 3 → illegal.
  - half with offset 1 or 3 → illegal.
  - word with offset ≠ 0 → illegal.
- States and transitions:
  - IDLE:
    - illegal request → ERR.
    - word request → WRITE, with memWData=reqData.
    - half/byte request → READ.
  - READ: memRe=1 for exactly 1 cycle with memAddr valid. Clear the counter, go to WAIT.
  - WAIT:
    - memRValid=1 → latch merged word, go to WRITE. memRValid is sampled only in WAIT, i.e. from the cycle after memRe onward; a memRValid that arrives with memRe is ignored.
    - otherwise increment the counter; when the counter reaches TIMEOUT-1 without memRValid → ERR.
  - WRITE: memWe=1 and done=1 in the same cycle. memAddr and memWData are held valid → IDLE.
  - ERR: error=1 for 1 cycle, memRe=memWe=0 → IDLE.
- Merge, starting from R=memRData and D=latched data:
  - half, offset 0: R[31:16]=D[15:0].
  - half, offset 2: R[15:0]=D[15:0].
  - byte, offset 0: R[31:24]=D[7:0].
  - byte, offset 1: R[23:16]=D[7:0].
  - byte, offset 2: R[15:8]=D[7:0].
  - byte, offset 3: R[7:0]=D[7:0].
  - All other lanes pass through unchanged.
- Upper bits of D are ignored for SH/SB.
- Latency from the accept edge:
  - word store: WRITE on the next cycle.
  - sub-word store: READ on +1, WAIT from +2, WRITE the cycle after memRValid is seen.
  - error: ERR on +1.
- done and error are never high together. memRe and memWe are never high together.
- Back-to-back: reqReady returns high the cycle after WRITE or ERR, so the fastest rate is one word store every 2 cycles.
- memAddr holds its value from accept until the next accept.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF → next cycle memWe=1, memAddr=0x100, memWData=0xDEADBEEF, done=1; no memRe.
- SB addr=0x203 data=0xFFFFFFAA, memory returns 0x11223344 two cycles after memRe → memAddr=0x200, memWData=0x112233AA, done with memWe; then SB offset 0 on the same word → 0xAA223344.
- SH addr=0x302 data=0x0000BEEF, memRData=0x11223344 → memWData=0x1122BEEF. SH offset 0 → 0xBEEF3344.
- SH addr=0x301, SW addr=0x402, and reqSize=3 → each gives error=1 one cycle after accept, with memRe=memWe=0 throughout.
- SB with memRValid never asserted, TIMEOUT=16 → error pulse after 16 WAIT cycles, no memWe, reqReady high on the next cycle.
- Assert rst_n=0 during WAIT → outputs clear asynchronously; a late memRValid after reset causes no memWe and no done.
